jogo_sequencia_param: RTL and testbench

Parametrised sequence-memory game controller, the successor to the fixed 4-key/16-entry experiment circuit. It plays a round-based game: round r requires the player to repeat memory entries 0..r in order. It supports N keys and configurable depth, and has an optional per-move timeout. It sits between the board switches/LEDs and an external sequence memory, with a debug bus for the 7-segment drivers.

---
 rtl/jogo_sequencia_param_if.sv | 34 +++
 rtl/jogo_sequencia_param.sv | 226 ++++++++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jogo_sequencia_param_if.sv
// ---------------------------------------------------------------------------
// jogo_sequencia_param_if
//
// Read bus between the sequence-game controller and the external sequence
// memory. The memory answers combinationally: mem_dado always reflects the
// word stored at mem_endereco.
//
// Signals:
//   mem_endereco  ADDR_W      read address, driven by the controller
//   mem_dado      NUM_CHAVES  expected move stored at that address
//
// Modports:
//   master  controller side (drives the address, receives the data)
//   slave   memory side     (receives the address, drives the data)
// ---------------------------------------------------------------------------
interface jogo_sequencia_param_if #(
  parameter int NUM_CHAVES = 4,
  parameter int ADDR_W     = 4
);

  logic [ADDR_W-1:0]     mem_endereco;
  logic [NUM_CHAVES-1:0] mem_dado;

  modport master (
    output mem_endereco,
    input  mem_dado
  );

  modport slave (
    input  mem_endereco,
    output mem_dado
  );

endinterface

// File: rtl/jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// jogo_sequencia_param
//
// Round-based sequence-memory game controller. Round r asks the player to
// repeat memory entries 0..r in order; the game is won after round
// PROFUNDIDADE-1 and lost on the first wrong move.
//
// Optional feature (compile-time macro TIMEOUT_EN):
//   defined   - a per-move timer runs while waiting for a key; if the player
//               stays idle for TIMEOUT_CICLOS cycles the game ends in
//               FIM_TIMEOUT.
//   undefined - no timer; `timeout` is tied low and the controller waits for
//               a key indefinitely.
//
// Parameters:
//   NUM_CHAVES      key count, memory word width and leds width
//   PROFUNDIDADE    sequence length / number of rounds (>= 2)
//   TIMEOUT_CICLOS  cycles allowed per move (only with TIMEOUT_EN)
//   ADDR_W          address / counter width
//
// Ports:
//   clock          system clock, all state on the rising edge
//   reset          asynchronous, active-high
//   iniciar        start/restart request (honoured in INICIAL and FIM states)
//   chaves         player keys, one-hot when pressed, zero when released
//   mem            read bus to the sequence memory (master side)
//   acertou        game won
//   errou          game lost (wrong move or timeout)
//   timeout        game lost by timeout
//   pronto         game over (any FIM state)
//   leds           last captured move
//   db_estado      state code for the 7-segment debug display
//   db_rodada      current round
//   db_contagem    current move index within the round
//   db_igual       captured move equals the memory word
//   db_tem_jogada  single-cycle pulse on a key-press edge
// ---------------------------------------------------------------------------
module jogo_sequencia_param #(
  parameter int NUM_CHAVES     = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int ADDR_W         = $clog2(PROFUNDIDADE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [NUM_CHAVES-1:0] chaves,
  jogo_sequencia_param_if.master mem,
  output logic                  acertou,
  output logic                  errou,
  output logic                  timeout,
  output logic                  pronto,
  output logic [NUM_CHAVES-1:0] leds,
  output logic [3:0]            db_estado,
  output logic [ADDR_W-1:0]     db_rodada,
  output logic [ADDR_W-1:0]     db_contagem,
  output logic                  db_igual,
  output logic                  db_tem_jogada
);

  // State codes are fixed so the debug display keeps its legacy meaning.
  localparam logic [3:0] INICIAL     = 4'd0;
  localparam logic [3:0] PREPARACAO  = 4'd1;
  localparam logic [3:0] ESPERA      = 4'd2;
  localparam logic [3:0] REGISTRA    = 4'd3;
  localparam logic [3:0] COMPARA     = 4'd4;
  localparam logic [3:0] PROX_JOGADA = 4'd5;
  localparam logic [3:0] PROX_RODADA = 4'd6;
  localparam logic [3:0] FIM_ACERTO  = 4'd10;
  localparam logic [3:0] FIM_ERRO    = 4'd14;
  localparam logic [3:0] FIM_TIMEOUT = 4'd15;

  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(PROFUNDIDADE - 1);

  logic [3:0]            estado;
  logic [3:0]            estado_prox;
  logic [ADDR_W-1:0]     rodada;
  logic [ADDR_W-1:0]     contagem;
  logic [NUM_CHAVES-1:0] jogada;
  logic [NUM_CHAVES-1:0] chaves_ant;
  logic                  tem_jogada;
  logic                  igual;
  logic                  limpa;
  logic                  timer_fim;

  // A move is the transition from "no key" to "some key"; holding a key
  // produces a single pulse and the key must go back to zero before the
  // next move can register.
  assign tem_jogada = (chaves != '0) && (chaves_ant == '0);

  // Multi-bit moves are compared verbatim, so they never match a one-hot
  // memory entry.
  assign igual = (jogada == mem.mem_dado);

  // Counters and the captured move are cleared on the edge that enters
  // PREPARACAO (so they already read zero there) and again on the way out.
  assign limpa = (estado_prox == PREPARACAO) || (estado == PREPARACAO);

  // -------------------------------------------------------------------------
  // Optional per-move timer
  // -------------------------------------------------------------------------
`ifdef TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_ULTIMO = TIMER_W'(TIMEOUT_CICLOS - 1);

  logic [TIMER_W-1:0] timer;

  assign timer_fim = (timer == TIMER_ULTIMO);

  // The timer only runs inside ESPERA and sits at zero everywhere else,
  // which clears it on every entry to ESPERA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (estado != ESPERA || limpa) begin
      timer <= '0;
    end else if (!timer_fim) begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign timeout = (estado == FIM_TIMEOUT);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CICLOS > 0);
  assign timer_fim          = 1'b0;
  assign timeout            = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL: begin
        if (iniciar) estado_prox = PREPARACAO;
      end
      PREPARACAO: begin
        estado_prox = ESPERA;
      end
      ESPERA: begin
        // A key press in the timer's last cycle still counts as a move.
        if (tem_jogada)     estado_prox = REGISTRA;
        else if (timer_fim) estado_prox = FIM_TIMEOUT;
      end
      REGISTRA: begin
        estado_prox = COMPARA;
      end
      COMPARA: begin
        if (!igual)                   estado_prox = FIM_ERRO;
        else if (contagem < rodada)   estado_prox = PROX_JOGADA;
        else if (rodada == ULTIMA_RODADA) estado_prox = FIM_ACERTO;
        else                          estado_prox = PROX_RODADA;
      end
      PROX_JOGADA,
      PROX_RODADA: begin
        estado_prox = ESPERA;
      end
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT: begin
        if (iniciar) estado_prox = PREPARACAO;
      end
      default: begin
        estado_prox = INICIAL;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters, captured move and key history
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      rodada     <= '0;
      contagem   <= '0;
      jogada     <= '0;
      chaves_ant <= '0;
    end else begin
      estado <= estado_prox;

      // The edge detector keeps tracking the keys in every state, so a key
      // already held when ESPERA is entered does not count as a new move.
      chaves_ant <= chaves;

      if (limpa) begin
        rodada   <= '0;
        contagem <= '0;
        jogada   <= '0;
      end else begin
        if (estado == REGISTRA) begin
          jogada <= chaves;
        end
        if (estado == PROX_JOGADA) begin
          contagem <= contagem + ADDR_W'(1);
        end
        // The FIM_ACERTO exit in COMPARA keeps rodada below PROFUNDIDADE.
        if (estado == PROX_RODADA) begin
          rodada   <= rodada + ADDR_W'(1);
          contagem <= '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (Moore, decoded from state and registers)
  // -------------------------------------------------------------------------
  assign mem.mem_endereco = contagem;

  assign acertou = (estado == FIM_ACERTO);
  assign errou   = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
  assign pronto  = (estado == FIM_ACERTO) || (estado == FIM_ERRO) ||
                   (estado == FIM_TIMEOUT);

  assign leds          = jogada;
  assign db_estado     = estado;
  assign db_rodada     = rodada;
  assign db_contagem   = contagem;
  assign db_igual      = igual;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// tb_jogo_sequencia_param
//
// Self-checking bench for jogo_sequencia_param with a 16-entry sequence
// memory modelled as an array. Directed scenarios cover reset, a full win,
// a wrong move, a held key, simultaneous keys and the idle behaviour in
// ESPERA (timeout when TIMEOUT_EN is defined). A randomized phase plays
// games on random memory contents and predicts the outcome from the game
// rules (round r = entries 0..r, first wrong move loses).
// ---------------------------------------------------------------------------
module tb_jogo_sequencia_param;

  localparam int NK   = 4;
  localparam int PROF = 16;
  localparam int AW   = 4;
  localparam int TOUT = 20;
`ifdef TIMEOUT_EN
  localparam int HOLD_LONGO = 15;
`else
  localparam int HOLD_LONGO = 40;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iniciar = 1'b0;
  logic [NK-1:0] chaves = '0;
  logic          acertou, errou, timeout, pronto;
  logic [NK-1:0] leds;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_rodada, db_contagem;
  logic          db_igual, db_tem_jogada;

  logic [NK-1:0] seq_mem [PROF];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  jogo_sequencia_param_if #(.NUM_CHAVES(NK), .ADDR_W(AW)) mif ();

  assign mif.mem_dado = seq_mem[mif.mem_endereco];

  jogo_sequencia_param #(
    .NUM_CHAVES(NK), .PROFUNDIDADE(PROF), .TIMEOUT_CICLOS(TOUT), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .mem(mif), .acertou(acertou), .errou(errou), .timeout(timeout),
    .pronto(pronto), .leds(leds), .db_estado(db_estado),
    .db_rodada(db_rodada), .db_contagem(db_contagem), .db_igual(db_igual),
    .db_tem_jogada(db_tem_jogada)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_fixed();
    logic [NK-1:0] tab [PROF];
    tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
            4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
    for (int k = 0; k < PROF; k++) seq_mem[k] = tab[k];
  endtask

  task automatic do_reset();
    chaves  = '0;
    iniciar = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Called at a negedge in INICIAL or FIM; returns at the negedge of the
  // first cycle spent in ESPERA.
  task automatic start_game();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    n_checks++; if (db_estado !== 4'd1) begin n_fail++; $display("FAIL start_preparacao: estado=%0d expected 1", db_estado); end
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL start_espera: estado=%0d expected 2", db_estado); end
  endtask

  // Holds k for `hold` cycles, then zero for `rel` cycles; counts pulses.
  task automatic play_move(input logic [NK-1:0] k, input int hold, input int rel,
                           output int pulses);
    pulses = 0;
    chaves = k;
    for (int c = 0; c < hold; c++) begin
      #1;
      if (db_tem_jogada) pulses++;
      @(negedge clock);
    end
    chaves = '0;
    repeat (rel) @(negedge clock);
  endtask

  task automatic play_round(input int r);
    int p;
    for (int i = 0; i <= r; i++) play_move(seq_mem[i], 10, 10, p);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado: estado=%0d expected 0", db_estado); end
    n_checks++; if ({acertou, errou, timeout, pronto} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: flags=%b expected 0000", {acertou, errou, timeout, pronto}); end
    n_checks++; if (leds !== 4'b0) begin n_fail++; $display("FAIL reset_leds: leds=%b expected 0000", leds); end
    n_checks++; if ({db_rodada, db_contagem} !== 8'h00) begin n_fail++; $display("FAIL reset_counters: rodada=%0d contagem=%0d expected 0 0", db_rodada, db_contagem); end
    do_reset();
    n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_idle: estado=%0d expected 0", db_estado); end
  endtask

  task automatic test_reset_mid_game();
    do_reset();
    start_game();
    for (int r = 0; r < 3; r++) play_round(r);
    n_checks++; if (db_estado !== 4'd2 || db_rodada !== 4'd3) begin n_fail++; $display("FAIL mid_pre: estado=%0d rodada=%0d expected 2 3", db_estado, db_rodada); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL mid_reset_estado: estado=%0d expected 0", db_estado); end
    n_checks++; if (db_rodada !== 4'd0) begin n_fail++; $display("FAIL mid_reset_rodada: rodada=%0d expected 0", db_rodada); end
    n_checks++; if ({acertou, errou, timeout, pronto} !== 4'b0) begin n_fail++; $display("FAIL mid_reset_flags: flags=%b expected 0000", {acertou, errou, timeout, pronto}); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_full_win();
    do_reset();
    start_game();
    for (int r = 0; r < PROF; r++) begin
      play_round(r);
      if (r < PROF - 1) begin
        n_checks++; if (db_estado !== 4'd2 || db_rodada !== 4'(r + 1)) begin n_fail++; $display("FAIL win_round%0d: estado=%0d rodada=%0d expected 2 %0d", r, db_estado, db_rodada, r + 1); end
      end
    end
    n_checks++; if ({acertou, pronto, errou} !== 3'b110) begin n_fail++; $display("FAIL win_flags: acertou/pronto/errou=%b expected 110", {acertou, pronto, errou}); end
    n_checks++; if (db_estado !== 4'd10 || db_rodada !== 4'd15) begin n_fail++; $display("FAIL win_state: estado=%0d rodada=%0d expected 10 15", db_estado, db_rodada); end
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    n_checks++; if (db_estado !== 4'd1 || db_rodada !== 4'd0 || db_contagem !== 4'd0) begin n_fail++; $display("FAIL win_restart: estado=%0d rodada=%0d contagem=%0d expected 1 0 0", db_estado, db_rodada, db_contagem); end
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd2 || pronto !== 1'b0) begin n_fail++; $display("FAIL win_restart_espera: estado=%0d pronto=%b expected 2 0", db_estado, pronto); end
  endtask

  task automatic test_error();
    int p;
    do_reset();
    start_game();
    for (int r = 0; r < 3; r++) play_round(r);
    play_move(seq_mem[0], 10, 10, p);
    play_move(seq_mem[1], 10, 10, p);
    chaves = 4'b1000;
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL err_registra: estado=%0d expected 3", db_estado); end
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd4 || leds !== 4'b1000 || db_igual !== 1'b0 || pronto !== 1'b0) begin n_fail++; $display("FAIL err_compara: estado=%0d leds=%b igual=%b pronto=%b expected 4 1000 0 0", db_estado, leds, db_igual, pronto); end
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd14 || {errou, pronto, acertou, timeout} !== 4'b1100) begin n_fail++; $display("FAIL err_fim: estado=%0d errou/pronto/acertou/timeout=%b expected 14 1100", db_estado, {errou, pronto, acertou, timeout}); end
    n_checks++; if (db_contagem !== 4'd2 || db_rodada !== 4'd3 || leds !== 4'b1000) begin n_fail++; $display("FAIL err_position: contagem=%0d rodada=%0d leds=%b expected 2 3 1000", db_contagem, db_rodada, leds); end
    chaves = '0;
    repeat (3) @(negedge clock);
    play_move(4'b0001, 10, 10, p);
    n_checks++; if (db_estado !== 4'd14 || leds !== 4'b1000) begin n_fail++; $display("FAIL err_keys_ignored: estado=%0d leds=%b expected 14 1000", db_estado, leds); end
  endtask

  task automatic test_held_key();
    int  pulses = 0;
    bit  saw_prox_rodada = 1'b0;
    do_reset();
    start_game();
    chaves = 4'b0001;
    for (int c = 0; c < HOLD_LONGO; c++) begin
      #1;
      if (db_tem_jogada) pulses++;
      if (db_estado == 4'd6) saw_prox_rodada = 1'b1;
      @(negedge clock);
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL held_pulses: pulses=%0d expected 1", pulses); end
    n_checks++; if (saw_prox_rodada !== 1'b1) begin n_fail++; $display("FAIL held_prox_rodada: seen=%0d expected 1", saw_prox_rodada); end
    n_checks++; if (db_estado !== 4'd2 || db_rodada !== 4'd1 || db_contagem !== 4'd0) begin n_fail++; $display("FAIL held_espera: estado=%0d rodada=%0d contagem=%0d expected 2 1 0", db_estado, db_rodada, db_contagem); end
    chaves = '0;
    repeat (10) @(negedge clock);
    n_checks++; if (db_estado !== 4'd2 || db_rodada !== 4'd1) begin n_fail++; $display("FAIL held_release: estado=%0d rodada=%0d expected 2 1", db_estado, db_rodada); end
  endtask

  task automatic test_simultaneous_keys();
    int p;
    do_reset();
    start_game();
    play_move(4'b0011, 10, 10, p);
    n_checks++; if (db_estado !== 4'd14 || errou !== 1'b1 || leds !== 4'b0011) begin n_fail++; $display("FAIL simult: estado=%0d errou=%b leds=%b expected 14 1 0011", db_estado, errou, leds); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_game();
`ifdef TIMEOUT_EN
    repeat (TOUT - 1) @(negedge clock);
    n_checks++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL tout_cycle20_still: estado=%0d expected 2", db_estado); end
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd15 || {timeout, errou, pronto, acertou} !== 4'b1110) begin n_fail++; $display("FAIL tout_fim: estado=%0d timeout/errou/pronto/acertou=%b expected 15 1110", db_estado, {timeout, errou, pronto, acertou}); end
    start_game();
    repeat (TOUT - 2) @(negedge clock);
    chaves = 4'b0001;
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL tout_press19: estado=%0d expected 3", db_estado); end
    chaves = '0;
    do_reset();
    start_game();
    repeat (TOUT - 1) @(negedge clock);
    chaves = 4'b0001;
    @(negedge clock);
    n_checks++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL tout_press20: estado=%0d expected 3", db_estado); end
    chaves = '0;
`else
    repeat (100) @(negedge clock);
    n_checks++; if (db_estado !== 4'd2 || timeout !== 1'b0 || pronto !== 1'b0) begin n_fail++; $display("FAIL idle_espera: estado=%0d timeout=%b pronto=%b expected 2 0 0", db_estado, timeout, pronto); end
`endif
  endtask

  // Random games on random one-hot memory contents. The expected position
  // after each move follows directly from the game rules.
  task automatic test_random_games();
    int            p;
    bit            fim;
    int            exp_estado, exp_rod, exp_cont;
    logic [NK-1:0] key;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < PROF; k++) seq_mem[k] = 4'(1 << $urandom_range(0, NK - 1));
      do_reset();
      start_game();
      fim = 1'b0;
      for (int r = 0; r < PROF && !fim; r++) begin
        for (int i = 0; i <= r && !fim; i++) begin
          key = seq_mem[i];
          if ($urandom_range(0, 39) == 0) begin
            do key = 4'($urandom_range(1, 15)); while (key == seq_mem[i]);
          end
          play_move(key, $urandom_range(2, 12), $urandom_range(2, 8), p);
          if (key != seq_mem[i]) begin
            exp_estado = 14; exp_rod = r; exp_cont = i; fim = 1'b1;
          end else if (i < r) begin
            exp_estado = 2; exp_rod = r; exp_cont = i + 1;
          end else if (r == PROF - 1) begin
            exp_estado = 10; exp_rod = r; exp_cont = i; fim = 1'b1;
          end else begin
            exp_estado = 2; exp_rod = r + 1; exp_cont = 0;
          end
          n_checks++; if (db_estado !== 4'(exp_estado) || db_rodada !== 4'(exp_rod) || db_contagem !== 4'(exp_cont)) begin n_fail++; $display("FAIL rand_g%0d_r%0d_m%0d: estado=%0d rodada=%0d contagem=%0d expected %0d %0d %0d", g, r, i, db_estado, db_rodada, db_contagem, exp_estado, exp_rod, exp_cont); fim = 1'b1; end
          n_checks++; if (leds !== key || p !== 1) begin n_fail++; $display("FAIL rand_g%0d_capture: leds=%b pulses=%0d expected %b 1", g, leds, p, key); end
        end
      end
    end
  endtask

  initial begin
    load_fixed();
    test_reset();
    test_reset_mid_game();
    test_full_win();
    test_error();
    test_held_key();
    test_simultaneous_keys();
    test_timeout();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
